// File: rtl/grf_multi.sv
// General register file: one write port, NRD combinational read ports with optional write bypass,
// plus a write-trace FIFO that records every committed write as {pc, addr, data}.
module grf_multi #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned NRD         = 2,
   parameter int unsigned BYPASS      = 1,
   parameter int unsigned ZERO_REG    = 1,
   parameter int unsigned TRACE_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NRD*ADDR_W-1:0]           raddr,
   output logic [NRD*DATA_W-1:0]           rdata,
   input  logic                            we,
   input  logic [ADDR_W-1:0]               waddr,
   input  logic [DATA_W-1:0]               wdata,
   input  logic [31:0]                     pc,
   output logic                            trace_valid,
   input  logic                            trace_ready,
   output logic [31:0]                     trace_pc,
   output logic [ADDR_W-1:0]               trace_addr,
   output logic [DATA_W-1:0]               trace_data,
   output logic [$clog2(TRACE_DEPTH):0]    trace_count,
   output logic                            trace_ovf
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned PtrW  = $clog2(TRACE_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned EntW  = 32 + ADDR_W + DATA_W;

   logic [DATA_W-1:0] regs_q [Depth];
   logic              commit;

   assign commit = we && !reset && !((ZERO_REG != 0) && (waddr == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(Depth); i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit) begin
         regs_q[waddr] <= wdata;
      end
   end

   for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr[g*ADDR_W +: ADDR_W];
      always_comb begin
         rdata[g*DATA_W +: DATA_W] = regs_q[ra];
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rdata[g*DATA_W +: DATA_W] = '0;
         end else if ((BYPASS != 0) && commit && (ra == waddr)) begin
            rdata[g*DATA_W +: DATA_W] = wdata;
         end
      end
   end

   // Trace FIFO; power-of-two depth lets the pointers wrap naturally.
   logic [EntW-1:0] mem_q [TRACE_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q;
   logic            full, pop, push_ok, drop;

   assign full    = (count_q == CntW'(TRACE_DEPTH));
   assign pop     = (count_q != '0) && trace_ready;
   assign push_ok = commit && (!full || pop);
   assign drop    = commit && full && !pop;

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= {pc, waddr, wdata};
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
         count_q <= count_d;
      end
   end

   assign trace_valid = (count_q != '0);
   assign trace_count = count_q;
   assign trace_ovf   = ovf_q;
   assign {trace_pc, trace_addr, trace_data} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_grf_multi.sv
// Self-checking bench for grf_multi: queue/array model checked every cycle plus directed literals.
module tb_grf_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] pc;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [4:0]  trace_addr;
   logic [31:0] trace_data;
   logic [2:0]  trace_count;
   logic        trace_ovf;

   grf_multi dut (
      .clk         (clk),
      .reset       (reset),
      .raddr       (raddr),
      .rdata       (rdata),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .pc          (pc),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_pc    (trace_pc),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .trace_count (trace_count),
      .trace_ovf   (trace_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic [31:0] m_regs [32];
   ent_t        m_q [$];
   bit          m_ovf;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         bit was_full;
         bit popped;
         was_full = (m_q.size() == 4);
         popped   = (m_q.size() > 0) && trace_ready;
         if (popped) void'(m_q.pop_front());
         if (we && waddr != 0) begin
            m_regs[waddr] = wdata;
            if (!was_full || popped) m_q.push_back('{pc: pc, addr: waddr, data: wdata});
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         for (int p = 0; p < 2; p++) begin
            logic [4:0]  ra;
            logic [31:0] exp;
            ra = raddr[p*5 +: 5];
            if (ra == 0) exp = '0;
            else if (we && !reset && waddr != 0 && ra == waddr) exp = wdata;
            else exp = m_regs[ra];
            chk($sformatf("rdata%0d@%0d", p, ra), 64'(rdata[p*32 +: 32]), 64'(exp));
         end
         chk("trace_valid", 64'(trace_valid), 64'(m_q.size() > 0));
         chk("trace_count", 64'(trace_count), 64'(m_q.size()));
         chk("trace_ovf", 64'(trace_ovf), 64'(m_ovf));
         if (m_q.size() > 0) begin
            chk("trace_head", {27'd0, trace_pc[31:0] ^ trace_data, trace_addr},
                {27'd0, m_q[0].pc ^ m_q[0].data, m_q[0].addr});
            chk("trace_data", 64'(trace_data), 64'(m_q[0].data));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      we = 1'b1; waddr = a; wdata = d; pc = p;
      cyc();
      we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0; pc = '0; trace_ready = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      check_en = 1'b1;

      // Reset state across every address
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         #3;
         chk("rst_rd0", 64'(rdata[31:0]), 64'd0);
         chk("rst_rd1", 64'(rdata[63:32]), 64'd0);
         cyc();
      end
      chk("rst_valid", 64'(trace_valid), 64'd0);
      chk("rst_count", 64'(trace_count), 64'd0);
      chk("rst_ovf", 64'(trace_ovf), 64'd0);

      // Bypass and trace latency
      raddr = {5'd5, 5'd5};
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; pc = 32'h3000;
      #3;
      chk("bypass_rd0", 64'(rdata[31:0]), 64'hDEADBEEF);
      chk("bypass_nofall", 64'(trace_valid), 64'd0);
      cyc();
      we = 1'b0;
      #3;
      chk("after_rd0", 64'(rdata[31:0]), 64'hDEADBEEF);
      chk("head_valid", 64'(trace_valid), 64'd1);
      chk("head_pc", 64'(trace_pc), 64'h3000);
      chk("head_addr", 64'(trace_addr), 64'd5);
      chk("head_data", 64'(trace_data), 64'hDEADBEEF);
      trace_ready = 1'b1;
      cyc();
      trace_ready = 1'b0;

      // Register 0 write is discarded and untraced
      raddr = {5'd0, 5'd0};
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      #3;
      chk("r0_bypass", 64'(rdata[31:0]), 64'd0);
      cyc();
      we = 1'b0;
      #3;
      chk("r0_read", 64'(rdata[31:0]), 64'd0);
      chk("r0_count", 64'(trace_count), 64'd0);
      cyc();

      // Overflow: five writes with no drain
      for (int i = 1; i <= 5; i++) wr(5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
      #3;
      chk("ovf_count", 64'(trace_count), 64'd4);
      chk("ovf_flag", 64'(trace_ovf), 64'd1);
      trace_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_addr", 64'(trace_addr), 64'(i));
         chk("drain_data", 64'(trace_data), 64'h100 + 64'(i));
         cyc();
         #3;
      end
      trace_ready = 1'b0;
      chk("drained_count", 64'(trace_count), 64'd0);
      chk("ovf_sticky", 64'(trace_ovf), 64'd1);
      cyc();

      // Full FIFO with simultaneous push and pop
      for (int i = 6; i <= 9; i++) wr(5'(i), 32'h200 + 32'(i), 32'h5000 + 32'(i));
      trace_ready = 1'b1;
      wr(5'd10, 32'h20A, 32'h500A);
      trace_ready = 1'b0;
      #3;
      chk("fullpp_count", 64'(trace_count), 64'd4);
      chk("fullpp_head", 64'(trace_addr), 64'd7);
      trace_ready = 1'b1;
      for (int i = 7; i <= 10; i++) begin
         chk("fullpp_order", 64'(trace_addr), 64'(i));
         cyc();
         #3;
      end
      trace_ready = 1'b0;
      cyc();

      // Mixed traffic: both ports reading around the write address
      for (int i = 11; i < 19; i++) begin
         raddr = {5'(i - 1), 5'(i)};
         trace_ready = i[0];
         wr(5'(i), 32'h11111111 * 32'(i - 10), 32'h6000 + 32'(i));
      end
      trace_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      trace_ready = 1'b0;

      // Reset mid-activity with a write in the reset cycle
      for (int i = 1; i <= 3; i++) wr(5'(i), 32'hA0 + 32'(i), 32'h7000);
      reset = 1'b1;
      we = 1'b1; waddr = 5'd7; wdata = 32'h77; pc = 32'h7777;
      cyc();
      reset = 1'b0; we = 1'b0;
      raddr = {5'd1, 5'd7};
      #3;
      chk("rst2_r7", 64'(rdata[31:0]), 64'd0);
      chk("rst2_r1", 64'(rdata[63:32]), 64'd0);
      chk("rst2_valid", 64'(trace_valid), 64'd0);
      chk("rst2_count", 64'(trace_count), 64'd0);
      chk("rst2_ovf", 64'(trace_ovf), 64'd0);
      cyc();
      raddr = {5'd3, 5'd2};
      #3;
      chk("rst2_r2", 64'(rdata[31:0]), 64'd0);
      chk("rst2_r3", 64'(rdata[63:32]), 64'd0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/grf_multi.md
Name: grf_multi

Overview:
- Parametrised general register file for the pipelined CPU: one write port, NRD combinational read ports, optional same-cycle write-to-read bypass.
- Includes a write-trace FIFO that records every committed write as {pc, addr, data} and drains it to a testbench or debug sink via valid/ready.
- Replaces the fixed 2-read, 32x32 file. Writes move to the rising edge, so a same-cycle read sees new data only through the bypass.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read whose address matches the write in the same cycle returns wdata.
- ZERO_REG, 1, 1 = register 0 is hardwired to 0; writes to it are discarded.
- TRACE_DEPTH, 4, trace FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- raddr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- pc  in  32  PC of the writing instruction; trace only.
- trace_valid  out  1  FIFO head entry is valid.
- trace_ready  in  1  sink accepts the head entry.
- trace_pc  out  32  head entry PC.
- trace_addr  out  ADDR_W  head entry address.
- trace_data  out  DATA_W  head entry data.
- trace_count  out  $clog2(TRACE_DEPTH)+1  current FIFO occupancy.
- trace_ovf  out  1  sticky flag: at least one trace entry was dropped.

Behaviour:
- Reset: sampled at the rising edge, priority over everything.
  - All registers are cleared to 0.
  - FIFO is emptied: trace_valid=0, trace_count=0.
  - trace_ovf is cleared to 0.
  - A write presented in the reset cycle is ignored and not traced.
- Commit: commit = we && !reset && !(ZERO_REG && waddr==0).
  - On commit, register[waddr] <= wdata at the rising edge.
  - The new value is visible on every read port from the next cycle.
- Reads: combinational.
  - ZERO_REG=1 and raddr_i==0 -> rdata_i = 0.
  - Otherwise, BYPASS=1 and commit and raddr_i==waddr -> rdata_i = wdata.
  - Otherwise rdata_i = register[raddr_i].
  - All ports are independent; any number may read the same address.
- Trace push: every commit pushes {pc, waddr, wdata}. Discarded reg-0 writes are not pushed.
- Trace pop: occurs when trace_valid && trace_ready at the rising edge.
- The trace_* head fields are valid only while trace_valid=1. Entry order is strict FIFO.
- Push latency: an entry pushed in cycle N is visible at the head, if the FIFO was empty, in cycle N+1. No fall-through.
- Full and push in the same cycle:
  - With a pop: both occur and the count is unchanged.
  - Without a pop: the entry is dropped, trace_ovf <= 1, and it stays 1 until reset.
- Empty and trace_ready=1: no effect.
- trace_count equals entries held, 0..TRACE_DEPTH.
- Pointers wrap modulo TRACE_DEPTH.
- Reset mid-drain: all pending entries are lost, with no flag.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0; trace_valid=0, trace_count=0, trace_ovf=0.
- Write 5 <= 0xDEADBEEF with pc=0x3000 while raddr0=5 -> rdata0=0xDEADBEEF in the same cycle (bypass) and in the next cycle. Trace head becomes {0x3000, 5, 0xDEADBEEF} one cycle later.
- we=1, waddr=0, wdata=0x1234 -> rdata for address 0 stays 0; trace_count unchanged.
- trace_ready=0, then 5 writes to regs 1..5 -> trace_count=4 and trace_ovf=1. Draining gives regs 1..4 in order; trace_ovf stays 1.
- FIFO full, a write plus trace_ready=1 in the same cycle -> count stays 4, the head advances, and the new entry lands at the tail.
- Fill regs 1..3 and assert reset for one cycle together with a write to reg 7 -> all registers 0, reg 7 not written, FIFO empty, trace_ovf=0.
